// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Plays a tune stored in an asynchronous SRAM as a square wave. Each 16-bit
// word is either a note (duration, octave, tone or rest) or a setting
// (tempo, halt, jump, nop). Notes are timed in milliseconds from a
// prescaler and end with a short silent articulation tail.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, STOP       level-sampled playback request / abort (STOP wins)
//   SRAM_A, SRAM_D    read address / read data
//   SRAM_WE..SRAM_UB  SRAM strobes, tied for read-only access
//   SPEAKER           square-wave audio
//   BUSY, DONE        status: running / halted by a HALT instruction
//   CUR_INS           last instruction latched from SRAM
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for START (after reset or STOP)
// FETCH  | SRAM_A = pc, wait SRAM_WAIT+1 cycles, latch SRAM_D
// EXEC   | one-cycle decode of the latched instruction
// PLAY   | note or rest in progress, ms prescaler and tone counter run
// DONE   | HALT executed, waiting for START to replay from address 0
// ---------------------------------------------------------------------------
module note_sequencer #(
    parameter int CLK_HZ          = 50000000,
    parameter int ADDR_W          = 18,
    parameter int SRAM_WAIT       = 2,
    parameter int DEFAULT_BEAT_MS = 625,
    parameter int ARTIC_MS        = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              SPEAKER,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       CUR_INS
);

    localparam int MS_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int WAIT_W = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam int TONE_W = 24;
    localparam int MS_W   = 17;   // 16 beats * 4095 ms fits
    localparam int BEAT_W = 12;

    // Octave-0 equal-tempered half periods in clock cycles, rounded.
    function automatic logic [TONE_W-1:0] half_of(input int t);
        real f0;
        real cyc;
        case (t)
            0:       f0 = 16.352;
            1:       f0 = 17.324;
            2:       f0 = 18.354;
            3:       f0 = 19.445;
            4:       f0 = 20.602;
            5:       f0 = 21.827;
            6:       f0 = 23.125;
            7:       f0 = 24.500;
            8:       f0 = 25.957;
            9:       f0 = 27.500;
            10:      f0 = 29.135;
            default: f0 = 30.868;
        endcase
        cyc = real'(CLK_HZ) / (2.0 * f0);
        half_of = TONE_W'($rtoi(cyc + 0.5));
    endfunction

    localparam logic [TONE_W-1:0] HALF_TBL [0:11] = '{
        half_of(0), half_of(1), half_of(2),  half_of(3),
        half_of(4), half_of(5), half_of(6),  half_of(7),
        half_of(8), half_of(9), half_of(10), half_of(11)
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_PLAY,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ins_q, ins_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic [TONE_W-1:0]   half_q, half_d;
    logic                spk_q, spk_d;
    logic                rest_q, rest_d;

    logic [ADDR_W-1:0]   pc_inc;
    logic [4:0]          dur;
    logic [MS_W-1:0]     note_ms;
    logic [TONE_W-1:0]   half_base;
    logic [TONE_W-1:0]   half_shift;
    logic [TONE_W-1:0]   half_eff;

    // Decode of the latched note word, used only in EXEC.
    always_comb begin
        pc_inc     = pc_q + ADDR_W'(1);
        dur        = (ins_q[11:8] == 4'd0) ? 5'd16 : {1'b0, ins_q[11:8]};
        note_ms    = MS_W'(dur) * MS_W'(beat_q);
        half_base  = '0;
        if (ins_q[3:0] < 4'd12) begin
            half_base = HALF_TBL[ins_q[3:0]];
        end
        half_shift = half_base >> ins_q[6:4];
        half_eff   = (half_shift == '0) ? TONE_W'(1) : half_shift;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
            beat_q  <= BEAT_W'(DEFAULT_BEAT_MS);
            wait_q  <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            tone_q  <= '0;
            half_q  <= '0;
            spk_q   <= 1'b0;
            rest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            tone_q  <= tone_d;
            half_q  <= half_d;
            spk_q   <= spk_d;
            rest_q  <= rest_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        beat_d  = beat_q;
        wait_d  = WAIT_W'(SRAM_WAIT);   // reloaded whenever not in FETCH
        pre_d   = pre_q;
        ms_d    = ms_q;
        tone_d  = tone_q;
        half_d  = half_q;
        spk_d   = 1'b0;
        rest_d  = rest_q;

        if (STOP) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        pc_d    = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (wait_q == '0) begin
                        ins_d   = SRAM_D;
                        state_d = ST_EXEC;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (!ins_q[15]) begin
                        pre_d   = PRE_W'(MS_CYC - 1);
                        ms_d    = note_ms;
                        half_d  = half_eff;
                        tone_d  = half_eff - TONE_W'(1);
                        rest_d  = (ins_q[3:0] >= 4'd12);
                        state_d = ST_PLAY;
                    end else begin
                        case (ins_q[14:12])
                            3'b000: begin
                                if (ins_q[11:0] != 12'd0) begin
                                    beat_d = ins_q[11:0];
                                end
                                pc_d    = pc_inc;
                                state_d = ST_FETCH;
                            end
                            3'b001: state_d = ST_DONE;
                            3'b010: begin
                                pc_d    = ADDR_W'({{ADDR_W{1'b0}}, ins_q[11:0]});
                                state_d = ST_FETCH;
                            end
                            default: begin
                                pc_d    = pc_inc;
                                state_d = ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_PLAY: begin
                    spk_d = spk_q;
                    if (tone_q == '0) begin
                        spk_d  = ~spk_q;
                        tone_d = half_q - TONE_W'(1);
                    end else begin
                        tone_d = tone_q - TONE_W'(1);
                    end
                    // ms_q counts whole milliseconds left; the last one
                    // ends the note when the prescaler expires.
                    if (pre_q == '0) begin
                        if (ms_q <= MS_W'(1)) begin
                            pc_d    = pc_inc;
                            spk_d   = 1'b0;
                            state_d = ST_FETCH;
                        end else begin
                            ms_d  = ms_q - MS_W'(1);
                            pre_d = PRE_W'(MS_CYC - 1);
                        end
                    end else begin
                        pre_d = pre_q - PRE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign SRAM_A  = pc_q;
    assign CUR_INS = ins_q;
    assign BUSY    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign DONE    = (state_q == ST_DONE);
    // Gated from registers only, so reset silences it without a clock edge.
    assign SPEAKER = (state_q == ST_PLAY) && spk_q && !rest_q
                     && (ms_q > MS_W'(ARTIC_MS));

    assign SRAM_WE = 1'b1;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, is the clock frequency in Hz.
REQ-002 Parameter ADDR_W, default 18, is the SRAM address width.
REQ-003 Parameter SRAM_WAIT, default 2, is the number of cycles from SRAM_A stable to SRAM_D valid.
REQ-004 Parameter DEFAULT_BEAT_MS, default 625, is the beat length in ms after reset (96 bpm).
REQ-005 Parameter ARTIC_MS, default 10, is the silent tail in ms at the end of every note.
REQ-006 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port START, input, 1 bit: level-sampled request to begin playback.
REQ-009 Port STOP, input, 1 bit: level-sampled abort request.
REQ-010 Port SRAM_A, output, ADDR_W bits: SRAM read address.
REQ-011 Port SRAM_D, input, 16 bits: SRAM read data.
REQ-012 Ports SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB and SRAM_UB, outputs, 1 bit each: tied constant 1, 0, 0, 0 and 0 (read-only).
REQ-013 Port SPEAKER, output, 1 bit: square-wave audio output.
REQ-014 Port BUSY, output, 1 bit: high in any state other than IDLE and DONE.
REQ-015 Port DONE, output, 1 bit: high in the DONE state.
REQ-016 Port CUR_INS, output, 16 bits: the last instruction latched.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, EXEC, PLAY and DONE.
REQ-018 IDLE: if START=1 and STOP=0, then pc<=0 and go to FETCH.
REQ-019 FETCH: drive SRAM_A=pc; after SRAM_WAIT+1 cycles in FETCH, latch SRAM_D into CUR_INS and go to EXEC.
REQ-020 Note format ([15]=0) SHALL decode as:
- [11:8] duration in beats, 0 = 16;
- [6:4] octave;
- [3:0] tone 0..11 (C..B);
- 12..15 = rest;
- bits [14:12] and [7] ignored.
REQ-021 Setting format ([15]=1), opcode [14:12], SHALL decode as:
- 000 SET_TEMPO: beat_ms<=[11:0]; a value of 0 leaves beat_ms unchanged;
- 001 HALT;
- 010 JUMP: pc<=zero-extended [11:0];
- other opcodes: NOP.
REQ-022 EXEC SHALL last one cycle, with these transitions:
- note: load counters, go to PLAY;
- SET_TEMPO or NOP: pc<=pc+1, go to FETCH;
- JUMP: go to FETCH;
- HALT: go to DONE.
REQ-023 A note's length SHALL be duration*beat_ms milliseconds, with 1 ms = CLK_HZ/1000 cycles (integer, elaboration-time constant) counted by a prescaler.
REQ-024 On completion of the note, pc<=pc+1 and the FSM goes to FETCH in the same cycle.
REQ-025 The half period in cycles SHALL be HALF[tone] >> octave, floored at 1.
REQ-026 HALF[tone] SHALL be round(CLK_HZ/(2*f0[tone])), computed at elaboration, with f0 the octave-0 equal-tempered table (C0 = 16.352 Hz, A0 = 27.5 Hz).
REQ-027 The tone counter SHALL be at least 24 bits wide.
REQ-028 In PLAY with a tone, SPEAKER SHALL toggle every half period, starting at 0 on PLAY entry.
REQ-029 SPEAKER SHALL be forced to 0 in every state other than PLAY, during rests, and during the final ARTIC_MS ms of each note.
REQ-030 A note whose total length is <= ARTIC_MS ms SHALL be entirely silent.
REQ-031 pc SHALL increment modulo 2^ADDR_W, so pc = 2^ADDR_W-1 advances to 0.
REQ-032 STOP=1 in any state SHALL return the FSM to IDLE on the next edge with SPEAKER=0, pc kept, and beat_ms kept.
REQ-033 STOP has priority over START when both are high in the same cycle.
REQ-034 DONE: START=1 and STOP=0 SHALL set pc<=0 and go to FETCH; beat_ms is not reset.
REQ-035 A JUMP to its own address SHALL loop forever without error; only STOP exits.

Reset
REQ-036 RST_N=0 SHALL immediately force:
- state IDLE;
- pc=0, SRAM_A=0, CUR_INS=0;
- SPEAKER=0, BUSY=0, DONE=0;
- beat_ms=DEFAULT_BEAT_MS;
- all counters 0.
REQ-037 Reset asserted mid-note SHALL silence SPEAKER without waiting for a clock edge.
REQ-038 After RST_N deasserts, the block SHALL stay in IDLE until START is seen.

Verification (CLK_HZ=2000, SRAM_WAIT=2, ARTIC_MS=1; 1 ms = 2 cycles)
REQ-039 Timing scenario: mem[0]=0x8004 (tempo 4 ms), mem[1]=0x0109 (1 beat A0), mem[2]=0x9000 (HALT); pulse START.
- Response: FETCH lasts 3 cycles.
- The note plays 8 cycles: 6 toggling at half period 36, then 2 silent.
- DONE rises and BUSY falls.
REQ-040 Octave/rest scenario: tempo 2 ms, then note 0x0239 (A0 octave 3, 2 beats), then 0x010C (rest).
- Response: half period 36>>3=4.
- The rest keeps SPEAKER=0 for 4 cycles.
REQ-041 Jump/wrap scenario: ADDR_W=4, mem[15]=note, mem[0]=0xA00F.
- Response: pc goes 15 -> 0 on wrap.
- The JUMP returns to 15 and playback loops until STOP.
REQ-042 Abort scenario: STOP mid-PLAY.
- Response: IDLE next edge, SPEAKER=0, pc retained.
- START and STOP high together keep the FSM in IDLE.
REQ-043 Reset scenario: RST_N low mid-note.
- Response: asynchronous SPEAKER=0, BUSY=0.
- beat_ms returns to DEFAULT_BEAT_MS, verified by a following 1-beat note lasting 1250 cycles.
REQ-044 Edge-value scenario: tempo 0x8000 and a duration-0 note.
- Response: beat_ms unchanged.
- The note lasts 16 beats.
